instr_fetch_queue: RTL and testbench

- Fetch stage that sits directly upstream of the 4-bit CPU's decode/execute path.
- Owns the program counter and issues reads to a synchronous 16x8 instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (jump/branch) with flush of the queue and of any read in flight.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/instr_fetch_queue.sv | 82 ++++++++
 tb/tb_instr_fetch_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU front end: widths, instruction fields,
// fetch FSM states and the queued fetch entry layout.
package cpu_pkg;
    localparam int AW = 4;
    localparam int IW = 8;
    localparam logic [3:0] NOP = 4'b0000;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fetch_state_e;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } fetch_entry_t;

    function automatic logic [3:0] opcode(input logic [IW-1:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [1:0] rd(input logic [IW-1:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] rs(input logic [IW-1:0] instr);
        return instr[1:0];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads a synchronous instruction memory and queues
// returned instructions for decode. Redirect flushes the queue and any read in flight.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = cpu_pkg::AW,
    parameter int IW    = cpu_pkg::IW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_rd_en,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [IW-1:0] ins_data,
    output logic [AW-1:0] ins_pc,
    output logic [CW-1:0] q_count
);
    cpu_pkg::fetch_state_e state;
    logic [AW-1:0]         pc;
    logic [AW-1:0]         inflight_pc;
    logic                  inflight;
    logic                  credit;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW+IW-1:0]      head;

    // Credit counts the read in flight as occupied, so the queue can never overflow.
    // Registered occupancy is used: a pop frees credit only on the following cycle.
    assign credit     = ({1'b0, q_count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign issue      = rst_n & fetch_en & ~redirect_valid & credit;
    assign imem_rd_en = issue;
    assign imem_addr  = pc;

    // A redirect kills the returning read; it is simply not written.
    assign push = inflight & ~redirect_valid;
    assign pop  = ins_valid & ins_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= cpu_pkg::IDLE;
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= fetch_en ? cpu_pkg::RUN : cpu_pkg::IDLE;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 1'b1;
            end
            if (redirect_valid) pc <= redirect_pc;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .W(AW+IW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({inflight_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ins_valid         = ~fifo_empty;
    assign {ins_pc, ins_data} = head;

    // Nothing issues while IDLE, so no read can be outstanding there.
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n) (state == cpu_pkg::IDLE) |-> !inflight);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a synchronous 16x8 memory model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int IW    = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          ins_valid;
    logic          ins_ready = 1'b0;
    logic [IW-1:0] ins_data;
    logic [AW-1:0] ins_pc;
    logic [CW-1:0] q_count;

    logic [IW-1:0] mem [16];
    int vectors = 0;
    int errors  = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    task automatic do_reset;
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; ins_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0; fetch_en = 1'b1; ins_ready = 1'b1;
        #1;
        vectors++;
        if ({imem_rd_en, imem_addr, ins_valid, ins_data, ins_pc, q_count} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {imem_rd_en, imem_addr, ins_valid, ins_data, ins_pc, q_count}); end
        repeat (2) @(negedge clk);
        vectors++;
        if ({imem_rd_en, ins_valid, q_count} !== '0)
            begin errors++; $display("FAIL reset_held: got %h expected 0", {imem_rd_en, ins_valid, q_count}); end
    endtask

    task automatic test_stream;
        logic [IW-1:0] ed [4];
        ed = '{8'h00, 8'h3D, 8'h28, 8'h19};
        do_reset(); ins_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); fetch_en = 1'b1; #1;
            vectors++;
            if ({imem_rd_en, imem_addr} !== {1'b1, AW'(c)})
                begin errors++; $display("FAIL stream_issue c%0d: got %b/%h expected 1/%h", c, imem_rd_en, imem_addr, c); end
            vectors++;
            if (ins_valid !== (c >= 2))
                begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", c, ins_valid, c >= 2); end
            if (c >= 2) begin
                vectors++;
                if ({ins_pc, ins_data} !== {AW'(c-2), ed[c-2]})
                    begin errors++; $display("FAIL stream_head c%0d: got %h/%h expected %h/%h", c, ins_pc, ins_data, c-2, ed[c-2]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int reads = 0;
        do_reset(); ins_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); fetch_en = 1'b1; #1;
            if (imem_rd_en) reads++;
        end
        vectors++;
        if (reads != 4) begin errors++; $display("FAIL bp_reads: got %0d expected 4", reads); end
        vectors++;
        if ({q_count, imem_rd_en} !== {3'd4, 1'b0})
            begin errors++; $display("FAIL bp_full: got cnt %0d rd %b expected 4/0", q_count, imem_rd_en); end
        @(negedge clk); ins_ready = 1'b1; #1;
        vectors++;
        if ({imem_rd_en, ins_pc, ins_data} !== {1'b0, 4'h0, 8'h00})
            begin errors++; $display("FAIL bp_pop_cycle: got %b/%h/%h expected 0/0/00", imem_rd_en, ins_pc, ins_data); end
        @(negedge clk); ins_ready = 1'b0; #1;
        vectors++;
        if ({q_count, imem_rd_en, imem_addr} !== {3'd3, 1'b1, 4'h4})
            begin errors++; $display("FAIL bp_after_pop: got %0d/%b/%h expected 3/1/4", q_count, imem_rd_en, imem_addr); end
        vectors++;
        if ({ins_pc, ins_data} !== {4'h1, 8'h3D})
            begin errors++; $display("FAIL bp_head: got %h/%h expected 1/3d", ins_pc, ins_data); end
    endtask

    task automatic test_redirect;
        do_reset(); ins_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); fetch_en = 1'b1; end
        #1;
        vectors++;
        if ({q_count, imem_rd_en} !== {3'd2, 1'b1})
            begin errors++; $display("FAIL redir_setup: got %0d/%b expected 2/1", q_count, imem_rd_en); end
        redirect_valid = 1'b1; redirect_pc = 4'hC; #1;
        vectors++;
        if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b expected 0", imem_rd_en); end
        @(negedge clk); redirect_valid = 1'b0; ins_ready = 1'b1; #1;
        vectors++;
        if ({q_count, ins_valid, imem_rd_en, imem_addr} !== {3'd0, 1'b0, 1'b1, 4'hC})
            begin errors++; $display("FAIL redir_flush: got %0d/%b/%b/%h expected 0/0/1/c", q_count, ins_valid, imem_rd_en, imem_addr); end
        @(negedge clk); #1;
        vectors++;
        if ({q_count, ins_valid} !== {3'd0, 1'b0})
            begin errors++; $display("FAIL redir_stale: got %0d/%b expected 0/0", q_count, ins_valid); end
        @(negedge clk); #1;
        vectors++;
        if ({ins_valid, ins_pc, ins_data} !== {1'b1, 4'hC, 8'h4C})
            begin errors++; $display("FAIL redir_target: got %b/%h/%h expected 1/c/4c", ins_valid, ins_pc, ins_data); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] ea [6];
        logic [IW-1:0] ed [4];
        ea = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
        ed = '{8'h4E, 8'h4F, 8'h00, 8'h3D};
        do_reset(); ins_ready = 1'b1;
        @(negedge clk); fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'hE; #1;
        vectors++;
        if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL wrap_redir_cycle: got %b expected 0", imem_rd_en); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); redirect_valid = 1'b0; #1;
            vectors++;
            if ({imem_rd_en, imem_addr} !== {1'b1, ea[c]})
                begin errors++; $display("FAIL wrap_issue c%0d: got %b/%h expected 1/%h", c, imem_rd_en, imem_addr, ea[c]); end
            if (c >= 2) begin
                vectors++;
                if ({ins_valid, ins_pc, ins_data} !== {1'b1, ea[c-2], ed[c-2]})
                    begin errors++; $display("FAIL wrap_head c%0d: got %b/%h/%h expected 1/%h/%h", c, ins_valid, ins_pc, ins_data, ea[c-2], ed[c-2]); end
            end
        end
    endtask

    task automatic test_fetch_gap;
        logic [11:0] fe, vld;
        logic [AW-1:0] ea [12];
        logic [AW-1:0] ep [12];
        logic [IW-1:0] ed [12];
        fe  = 12'b1111_1100_0111;   // bit c = fetch_en in cycle c
        vld = 12'b1111_0001_1100;
        ea  = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        ep  = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h3, 4'h4, 4'h5, 4'h6};
        ed  = '{8'h00, 8'h00, 8'h00, 8'h3D, 8'h28, 8'h00, 8'h00, 8'h00, 8'h19, 8'h44, 8'h45, 8'h46};
        do_reset(); ins_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); fetch_en = fe[c]; #1;
            vectors++;
            if (imem_rd_en !== fe[c])
                begin errors++; $display("FAIL gap_rd c%0d: got %b expected %b", c, imem_rd_en, fe[c]); end
            if (fe[c]) begin
                vectors++;
                if (imem_addr !== ea[c]) begin errors++; $display("FAIL gap_addr c%0d: got %h expected %h", c, imem_addr, ea[c]); end
            end
            vectors++;
            if (ins_valid !== vld[c]) begin errors++; $display("FAIL gap_valid c%0d: got %b expected %b", c, ins_valid, vld[c]); end
            if (vld[c]) begin
                vectors++;
                if ({ins_pc, ins_data} !== {ep[c], ed[c]})
                    begin errors++; $display("FAIL gap_head c%0d: got %h/%h expected %h/%h", c, ins_pc, ins_data, ep[c], ed[c]); end
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset(); ins_ready = 1'b1;
        repeat (5) begin @(negedge clk); fetch_en = 1'b1; end
        @(posedge clk); #3;
        vectors++;
        if (ins_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", ins_valid); end
        rst_n = 1'b0; #1;
        vectors++;
        if ({imem_rd_en, imem_addr, ins_valid, ins_data, ins_pc, q_count} !== '0)
            begin errors++; $display("FAIL areset_zero: got %h expected 0", {imem_rd_en, imem_addr, ins_valid, ins_data, ins_pc, q_count}); end
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 4'h0})
            begin errors++; $display("FAIL areset_restart: got %b/%h expected 1/0", imem_rd_en, imem_addr); end
        @(negedge clk); #1;
        vectors++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 4'h1})
            begin errors++; $display("FAIL areset_next: got %b/%h expected 1/1", imem_rd_en, imem_addr); end
        @(negedge clk); #1;
        vectors++;
        if ({ins_valid, ins_pc, ins_data} !== {1'b1, 4'h0, 8'h00})
            begin errors++; $display("FAIL areset_head: got %b/%h/%h expected 1/0/00", ins_valid, ins_pc, ins_data); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
        mem[0] = 8'h00; mem[1] = 8'h3D; mem[2] = 8'h28; mem[3] = 8'h19;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_gap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
